uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
Next-generation UART receiver for the FPGA/ASIC serial path. It supersedes the fixed-format receiver with run-time selectable parity (none/even/odd) and stop bits (1/2), per-frame parity and framing error flags, break detection, and a first-word-fall-through receive FIFO with valid/ready read handshake and a sticky overrun flag. It sits between the synchronised pad input and the host/debug logic that consumes bytes.

Parameters:
CLK_BITS, 16, width of the bit-period divisor.
DATA_WIDTH, 8, data bits per frame (5..9).
FIFO_DEPTH, 8, receive FIFO entries; power of 2, >=2.

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
clk_per_bit  in  CLK_BITS  clocks per bit; >=4; latched at start-bit detection
parity_mode  in  2  00 none, 01 even, 10 odd, 11 none; latched at start detect
stop_bits  in  1  0 = one stop bit, 1 = two; latched at start detect
rx_in  in  1  serial line, idle high, asynchronous to clk
rd_data  out  DATA_WIDTH  FIFO head data
rd_parity_err  out  1  parity error flag of head entry
rd_frame_err  out  1  framing error flag of head entry
rd_valid  out  1  FIFO non-empty
rd_ready  in  1  consumer accepts head when rd_valid=1
fifo_count  out  $clog2(FIFO_DEPTH)+1  occupied entries
overrun  out  1  sticky: frame dropped because FIFO full
clr_overrun  in  1  clears overrun
break_det  out  1  one-cycle pulse on break detection

Behaviour:
- Reset: all outputs 0; FIFO empty; state IDLE; both synchroniser flops = 1 (no false start after reset). Reset mid-frame abandons the frame, nothing pushed.
- rx_in passes through a 2-flop synchroniser (rx_s); all sampling uses rx_s.
- Bit counter cnt is CLK_BITS wide; a "bit tick" occurs when cnt == cpb-1, where cpb is the latched clk_per_bit; cnt then restarts at 0.
- IDLE: rx_s==0 -> latch config, cnt=0, go to START.
- START: at cnt == (cpb-1)>>1, sample rx_s. A 1 means a glitch: return to IDLE, no push. A 0 gives cnt=0, go to DATA. All subsequent samples fall at mid-bit.
- DATA: on each bit tick, shift in rx_s LSB-first. After DATA_WIDTH bits go to PARITY if the parity mode is even/odd, otherwise to STOP1.
- PARITY: on bit tick, sample p. Even mode: perr = ^data ^ p. Odd mode: perr = ~(^data ^ p). No parity: perr = 0.
- STOP1: on bit tick, sample s1.
  - Break: data==0, p==0 (if parity is used) and s1==0. Then pulse break_det for 1 cycle, push nothing, go to BRK_WAIT.
  - Otherwise, s1==0 sets ferr. With stop_bits=0, push {ferr,perr,data} in this same cycle and go to IDLE. With stop_bits=1, go to STOP2.
- STOP2: on bit tick, sample s2. ferr |= ~s2. Push, then go to IDLE.
- BRK_WAIT: stay until rx_s==1, then go to IDLE.
- Push cycle: the cycle of the last stop sample. rd_valid rises on the next cycle (1-cycle latency).
- FIFO behaviour:
  - First-word-fall-through: rd_data, rd_parity_err and rd_frame_err show the head whenever rd_valid=1; they hold 0 or stale values when empty (don't care).
  - Pop when rd_valid && rd_ready.
  - Pointers wrap modulo FIFO_DEPTH.
  - Push while full with no pop: frame dropped, overrun set.
  - Push while full with a simultaneous pop: push accepted, fifo_count unchanged.
  - Push and pop while non-empty: count unchanged.
  - rd_ready while empty is ignored.
- overrun: set has priority over clr_overrun in the same cycle.
- clk_per_bit, parity_mode and stop_bits changes during a frame have no effect until the next start bit. clk_per_bit<4 is unsupported.

Test Plan:
1. cpb=10, parity none, 1 stop, frame 0xA5 -> one cycle after the stop-bit sample: rd_valid=1, rd_data=0xA5, both error flags 0, fifo_count=1. Then rd_ready=1 for 1 cycle -> fifo_count=0, rd_valid=0.
2. Parity checks, 2 stop bits:
   - Even mode, 0x03 with p=1 -> rd_parity_err=1.
   - Even mode, 0x03 with p=0 -> rd_parity_err=0.
   - Odd mode, 0x03 with p=1 -> rd_parity_err=0.
   - Second stop bit driven 0 -> rd_frame_err=1, entry still pushed.
3. Parity none, data 0x55 with stop bit 0 -> entry 0x55 with rd_frame_err=1. rx low for 20 bit periods -> exactly one break_det pulse, no entry. After rx returns high, a following frame 0x3C is received correctly.
4. FIFO_DEPTH=4, rd_ready=0, send 0x11..0x55 -> fifo_count=4, overrun=1, reads return 0x11,0x22,0x33,0x44. Assert clr_overrun -> overrun=0. Full FIFO with push and pop in the same cycle -> count stays 4, no overrun.
5. cpb=16, rx low for 2 cycles -> no entry, state back in IDLE. Assert rst in the middle of the data bits of a frame -> fifo_count=0, all outputs 0. The next clean frame 0x7E is received correctly.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// UART receiver with run-time parity/stop-bit selection, break detection and
// a first-word-fall-through receive FIFO carrying per-frame error flags.
module uart_rx_fifo #(
  parameter int unsigned CLK_BITS   = 16,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CLK_BITS-1:0]           clk_per_bit,
  input  logic [1:0]                    parity_mode,
  input  logic                          stop_bits,
  input  logic                          rx_in,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic                          rd_parity_err,
  output logic                          rd_frame_err,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overrun,
  input  logic                          clr_overrun,
  output logic                          break_det
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned EntW = DATA_WIDTH + 2;
  localparam int unsigned IdxW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [2:0] {
    StIdle, StStart, StData, StParity, StStop1, StStop2, StBrkWait
  } state_e;

  state_e                  state_q, state_d;
  logic                    rx_meta_q, rx_s_q;
  logic [CLK_BITS-1:0]     cnt_q, cnt_d, cpb_q, cpb_d;
  logic                    par_q, par_d, odd_q, odd_d, two_q, two_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    p_q, p_d, perr_q, perr_d, ferr_q, ferr_d;
  logic                    push;
  logic [EntW-1:0]         push_ent;
  logic                    tick;
  logic [CLK_BITS-1:0]     half;

  assign tick = (cnt_q == cpb_q - CLK_BITS'(1));
  assign half = (cpb_q - CLK_BITS'(1)) >> 1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= StIdle;
      cnt_q     <= '0;
      cpb_q     <= '0;
      par_q     <= 1'b0;
      odd_q     <= 1'b0;
      two_q     <= 1'b0;
      idx_q     <= '0;
      data_q    <= '0;
      p_q       <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      rx_meta_q <= rx_in;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cpb_q     <= cpb_d;
      par_q     <= par_d;
      odd_q     <= odd_d;
      two_q     <= two_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      p_q       <= p_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CLK_BITS'(1);
    cpb_d     = cpb_q;
    par_d     = par_q;
    odd_d     = odd_q;
    two_d     = two_q;
    idx_d     = idx_q;
    data_d    = data_q;
    p_d       = p_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    push      = 1'b0;
    push_ent  = {ferr_q, perr_q, data_q};
    break_det = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (!rx_s_q) begin
          cpb_d   = clk_per_bit;
          par_d   = parity_mode[0] ^ parity_mode[1];
          odd_d   = parity_mode[1];
          two_d   = stop_bits;
          state_d = StStart;
        end
      end
      StStart: begin
        if (cnt_q == half) begin
          if (rx_s_q) begin
            state_d = StIdle;
          end else begin
            cnt_d   = '0;
            idx_d   = '0;
            p_d     = 1'b0;
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
            state_d = StData;
          end
        end
      end
      StData: begin
        if (tick) begin
          cnt_d  = '0;
          data_d = {rx_s_q, data_q[DATA_WIDTH-1:1]};
          idx_d  = idx_q + IdxW'(1);
          if (idx_q == IdxW'(DATA_WIDTH - 1)) state_d = par_q ? StParity : StStop1;
        end
      end
      StParity: begin
        if (tick) begin
          cnt_d   = '0;
          p_d     = rx_s_q;
          perr_d  = (^data_q) ^ rx_s_q ^ odd_q;
          state_d = StStop1;
        end
      end
      StStop1: begin
        if (tick) begin
          cnt_d = '0;
          // p_q stays 0 without parity, so the break test covers both formats
          if (data_q == '0 && !p_q && !rx_s_q) begin
            break_det = 1'b1;
            state_d   = StBrkWait;
          end else begin
            ferr_d = ~rx_s_q;
            if (two_q) begin
              state_d = StStop2;
            end else begin
              push     = 1'b1;
              push_ent = {~rx_s_q, perr_q, data_q};
              state_d  = StIdle;
            end
          end
        end
      end
      StStop2: begin
        if (tick) begin
          cnt_d    = '0;
          push     = 1'b1;
          push_ent = {ferr_q | ~rx_s_q, perr_q, data_q};
          state_d  = StIdle;
        end
      end
      StBrkWait: begin
        cnt_d = '0;
        if (rx_s_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  logic [EntW-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic            pop, full, wr_en;

  assign rd_valid = (fifo_count != '0);
  assign full     = (fifo_count == (PtrW + 1)'(FIFO_DEPTH));
  assign pop      = rd_valid && rd_ready;
  assign wr_en    = push && (!full || pop);
  assign {rd_frame_err, rd_parity_err, rd_data} = mem_q[rd_ptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_count <= '0;
      overrun    <= 1'b0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q] <= push_ent;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (wr_en && !pop)      fifo_count <= fifo_count + (PtrW + 1)'(1);
      else if (!wr_en && pop) fifo_count <= fifo_count - (PtrW + 1)'(1);
      // a dropped frame wins over a same-cycle clear
      if (push && full && !pop) overrun <= 1'b1;
      else if (clr_overrun)     overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: stimulus queues expected FIFO entries,
// a monitor pops and compares them whenever the DUT hands over a byte.
module tb_uart_rx_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] clk_per_bit;
  logic [1:0]  parity_mode;
  logic        stop_bits;
  logic        rx_in;
  logic [7:0]  rd_data;
  logic        rd_parity_err, rd_frame_err, rd_valid, rd_ready;
  logic [2:0]  fifo_count;
  logic        overrun, clr_overrun, break_det;

  uart_rx_fifo #(.CLK_BITS(16), .DATA_WIDTH(8), .FIFO_DEPTH(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .clk_per_bit   (clk_per_bit),
    .parity_mode   (parity_mode),
    .stop_bits     (stop_bits),
    .rx_in         (rx_in),
    .rd_data       (rd_data),
    .rd_parity_err (rd_parity_err),
    .rd_frame_err  (rd_frame_err),
    .rd_valid      (rd_valid),
    .rd_ready      (rd_ready),
    .fifo_count    (fifo_count),
    .overrun       (overrun),
    .clr_overrun   (clr_overrun),
    .break_det     (break_det)
  );

  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         brk_cnt = 0;
  logic [9:0] exp_q [$];   // {ferr, perr, data}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (break_det === 1'b1) brk_cnt++;
      if (rd_valid === 1'b1 && rd_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_entry: got 0x%0h, expected no entry",
                   {rd_frame_err, rd_parity_err, rd_data});
        end else begin
          check("fifo_head", {22'd0, rd_frame_err, rd_parity_err, rd_data},
                {22'd0, exp_q.pop_front()});
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bit_period(input logic b, input int cpb);
    rx_in = b;
    repeat (cpb) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input int cpb, input logic [1:0] pm,
                      input logic pbit, input logic two, input logic s1, input logic s2);
    clk_per_bit = 16'(cpb);
    parity_mode = pm;
    stop_bits   = two;
    bit_period(1'b0, cpb);
    for (int i = 0; i < 8; i++) bit_period(d[i], cpb);
    if (pm == 2'b01 || pm == 2'b10) bit_period(pbit, cpb);
    bit_period(s1, cpb);
    if (two) bit_period(s2, cpb);
    bit_period(1'b1, 2 * cpb);
  endtask

  task automatic read_one();
    int t = 0;
    while (rd_valid !== 1'b1 && t < 400) begin
      step();
      t++;
    end
    if (rd_valid !== 1'b1) begin
      check("read_timeout", {31'd0, rd_valid}, 32'd1);
    end else begin
      rd_ready = 1'b1;
      step();
      rd_ready = 1'b0;
    end
  endtask

  initial begin
    int brk0;
    rst = 1'b1; rx_in = 1'b1; rd_ready = 1'b0; clr_overrun = 1'b0;
    clk_per_bit = 16'd10; parity_mode = 2'b00; stop_bits = 1'b0;
    fork
      monitor();
      begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
      end
    join_none

    repeat (3) step();
    check("rst_valid", {31'd0, rd_valid}, 32'd0);
    check("rst_count", {29'd0, fifo_count}, 32'd0);
    check("rst_outs", {20'd0, overrun, break_det, rd_frame_err, rd_parity_err, rd_data}, 32'd0);
    rst = 1'b0;
    repeat (5) step();

    // Frame 8N1 0xA5, valid one cycle after the stop sample
    exp_q.push_back({2'b00, 8'hA5});
    fork
      send(8'hA5, 10, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
      begin
        repeat (97) @(posedge clk);
        #1;
        check("t1_valid_before_push", {31'd0, rd_valid}, 32'd0);
        @(posedge clk);
        #1;
        check("t1_valid_latency", {31'd0, rd_valid}, 32'd1);
        check("t1_count", {29'd0, fifo_count}, 32'd1);
      end
    join
    read_one();
    check("t1_count_after_pop", {29'd0, fifo_count}, 32'd0);
    check("t1_valid_after_pop", {31'd0, rd_valid}, 32'd0);

    // Parity and second stop bit
    exp_q.push_back({2'b01, 8'h03});
    send(8'h03, 10, 2'b01, 1'b1, 1'b1, 1'b1, 1'b1);
    read_one();
    exp_q.push_back({2'b00, 8'h03});
    send(8'h03, 10, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1);
    read_one();
    exp_q.push_back({2'b00, 8'h03});
    send(8'h03, 10, 2'b10, 1'b1, 1'b1, 1'b1, 1'b1);
    read_one();
    exp_q.push_back({2'b01, 8'h03});
    send(8'h03, 10, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1);
    read_one();
    exp_q.push_back({2'b10, 8'h03});
    send(8'h03, 10, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0);
    read_one();

    // Framing error, then break, then recovery
    brk0 = brk_cnt;
    exp_q.push_back({2'b10, 8'h55});
    send(8'h55, 10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    read_one();
    check("t3_no_break_on_ferr", 32'(brk_cnt - brk0), 32'd0);
    rx_in = 1'b0;
    repeat (200) step();
    rx_in = 1'b1;
    repeat (30) step();
    check("t3_break_pulses", 32'(brk_cnt - brk0), 32'd1);
    check("t3_break_no_entry", {29'd0, fifo_count}, 32'd0);
    exp_q.push_back({2'b00, 8'h3C});
    send(8'h3C, 10, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
    read_one();

    // Overrun with depth 4
    for (int v = 1; v <= 5; v++) begin
      if (v <= 4) exp_q.push_back({2'b00, 8'(v * 17)});
      send(8'(v * 17), 10, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
    end
    check("t4_count_full", {29'd0, fifo_count}, 32'd4);
    check("t4_overrun_set", {31'd0, overrun}, 32'd1);
    repeat (4) read_one();
    check("t4_count_drained", {29'd0, fifo_count}, 32'd0);
    check("t4_overrun_sticky", {31'd0, overrun}, 32'd1);
    clr_overrun = 1'b1;
    step();
    clr_overrun = 1'b0;
    check("t4_overrun_cleared", {31'd0, overrun}, 32'd0);
    for (int v = 1; v <= 4; v++) begin
      exp_q.push_back({2'b00, 8'h60 + 8'(v)});
      send(8'h60 + 8'(v), 10, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
    end
    check("t4_refill", {29'd0, fifo_count}, 32'd4);
    // Pop lands in the same cycle as the push of 0x65
    exp_q.push_back({2'b00, 8'h65});
    fork
      send(8'h65, 10, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
      begin
        repeat (97) @(posedge clk);
        #1;
        rd_ready = 1'b1;
        @(posedge clk);
        #1;
        rd_ready = 1'b0;
      end
    join
    check("t4_push_pop_count", {29'd0, fifo_count}, 32'd4);
    check("t4_push_pop_no_overrun", {31'd0, overrun}, 32'd0);
    repeat (4) read_one();

    // Start glitch, then reset mid-frame
    clk_per_bit = 16'd16;
    rx_in = 1'b0;
    step();
    step();
    rx_in = 1'b1;
    repeat (40) step();
    check("t5_glitch_no_entry", {29'd0, fifo_count}, 32'd0);
    exp_q.push_back({2'b00, 8'h5A});
    send(8'h5A, 16, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
    check("t5_after_glitch_frame", {29'd0, fifo_count}, 32'd1);
    bit_period(1'b0, 16);
    bit_period(1'b0, 16);
    bit_period(1'b1, 16);
    rst = 1'b1;
    exp_q.delete();
    step();
    check("t5_rst_count", {29'd0, fifo_count}, 32'd0);
    check("t5_rst_outs", {20'd0, overrun, break_det, rd_frame_err, rd_parity_err, rd_data},
          32'd0);
    check("t5_rst_valid", {31'd0, rd_valid}, 32'd0);
    step();
    rst = 1'b0;
    repeat (40) step();
    check("t5_no_push_after_rst", {29'd0, fifo_count}, 32'd0);
    exp_q.push_back({2'b00, 8'h7E});
    send(8'h7E, 16, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
    read_one();
    check("t5_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
